// File: rtl/memory_map_io.sv
// memory_map_io: CPU data-port decoder with RAM, memory-mapped I/O, sticky buttons and 4-digit hex scanner
module memory_map_io #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int RAM_DEPTH   = 3840,
  parameter int IO_BASE     = 3840,
  parameter int IO_COUNT    = 16,
  parameter int DEBUG_COUNT = 4,
  parameter int BTN_W       = 4,
  parameter int SCAN_DIV    = 1024,
  localparam int SEL_W      = DEBUG_COUNT > 1 ? $clog2(DEBUG_COUNT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              writeM,
  input  logic [ADDR_W-1:0] addressM,
  input  logic [DATA_W-1:0] outM,
  output logic [DATA_W-1:0] inM,
  input  logic [BTN_W-1:0]  btn_in,
  input  logic [SEL_W-1:0]  dbg_sel,
  output logic [DATA_W-1:0] led_out,
  output logic [6:0]        seg_out,
  output logic [3:0]        seg_an
);
  localparam int IDX_W = IO_COUNT > 1 ? $clog2(IO_COUNT) : 1;
  localparam int RA_W  = RAM_DEPTH > 1 ? $clog2(RAM_DEPTH) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int DBG0  = IO_COUNT - DEBUG_COUNT;
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [31:0] addr_w;
  logic ram_hit, io_hit, btn_rd, ram_sel_q;
  logic [IDX_W-1:0] k, dbg_idx;
  logic [SEL_W-1:0] sel;
  logic [DATA_W-1:0] mem [RAM_DEPTH];
  logic [DATA_W-1:0] io_q [IO_COUNT];
  logic [DATA_W-1:0] ram_rd_q, io_rd_q, io_rd_d, btn_val;
  logic [BTN_W-1:0] sync_q, lvl_q, edge_q, edge_d, rise;
  logic [PRE_W-1:0] pre_q;
  logic [1:0] d_q;
  logic on_q, wrap;
  logic [DATA_W+15:0] ext;
  logic [3:0] nib, an_q, an_d;
  logic [6:0] seg_q, seg_d;

  assign addr_w  = 32'(addressM);
  assign ram_hit = addr_w < RAM_DEPTH;
  assign io_hit  = !ram_hit && addr_w >= IO_BASE && addr_w < IO_BASE + IO_COUNT;
  assign k       = IDX_W'(addr_w - 32'(IO_BASE));
  assign btn_rd  = io_hit && k == IDX_W'(1);
  assign btn_val = DATA_W'({edge_q, lvl_q});
  assign io_rd_d = !io_hit ? '0 : btn_rd ? btn_val : io_q[k];
  assign rise    = sync_q & ~lvl_q;
  // a fresh rising edge survives the read that clears the older ones
  assign edge_d  = btn_rd ? rise : edge_q | rise;
  assign inM     = ram_sel_q ? ram_rd_q : io_rd_q;
  assign led_out = io_q[0];
  assign seg_out = seg_q;
  assign seg_an  = an_q;

  if ((1 << SEL_W) == DEBUG_COUNT) begin : g_sel_p2
    assign sel = dbg_sel;
  end else begin : g_sel_np2
    assign sel = (32'(dbg_sel) < DEBUG_COUNT) ? dbg_sel : '0;
  end

  assign dbg_idx = IDX_W'(DBG0) + IDX_W'(sel);
  assign ext     = {16'b0, io_q[dbg_idx]};
  assign nib     = ext[{d_q, 2'b00} +: 4];
  assign wrap    = pre_q == PRE_W'(SCAN_DIV - 1);
  assign seg_d   = on_q ? SEG[nib] : 7'h7F;
  assign an_d    = on_q ? ~(4'b0001 << d_q) : 4'hF;

  always_ff @(posedge clk) begin
    if (writeM && ram_hit) mem[addr_w[RA_W-1:0]] <= outM;
    ram_rd_q <= mem[addr_w[RA_W-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IO_COUNT; i++) io_q[i] <= '0;
      io_rd_q   <= '0;
      ram_sel_q <= 1'b0;
      sync_q    <= '0;
      lvl_q     <= '0;
      edge_q    <= '0;
      pre_q     <= '0;
      d_q       <= '0;
      on_q      <= 1'b0;
      seg_q     <= 7'h7F;
      an_q      <= 4'hF;
    end else begin
      if (writeM && io_hit && !btn_rd) io_q[k] <= outM;
      io_rd_q   <= io_rd_d;
      ram_sel_q <= ram_hit;
      sync_q    <= btn_in;
      lvl_q     <= sync_q;
      edge_q    <= edge_d;
      pre_q     <= wrap ? '0 : pre_q + 1'b1;
      d_q       <= d_q + {1'b0, wrap};
      on_q      <= on_q | wrap;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end
endmodule

// File: tb/tb_memory_map_io.sv
// tb_memory_map_io: randomized scoreboard bench for memory_map_io against a behavioural model
module tb_memory_map_io;
  logic        clk = 0, rst = 1, writeM = 0;
  logic [15:0] addressM = 0, outM = 0, inM, led_out;
  logic [3:0]  btn_in = 0, seg_an, btn_cur = 0;
  logic [1:0]  dbg_sel = 0;
  logic [6:0]  seg_out;

  memory_map_io #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .writeM(writeM), .addressM(addressM), .outM(outM), .inM(inM),
    .btn_in(btn_in), .dbg_sel(dbg_sel), .led_out(led_out), .seg_out(seg_out), .seg_an(seg_an)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  typedef struct {bit chk_in; logic [15:0] inm; logic [15:0] led; logic [6:0] seg; logic [3:0] an;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;

  logic [15:0] ram_m [int];
  logic [15:0] io_m [16];
  logic [3:0]  s1, s2, edge_m;
  int          n_edges;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (io_m[i]) io_m[i] = '0;
    s1 = 0; s2 = 0; edge_m = 0; n_edges = 0;
  endtask

  task automatic step(input bit we, input logic [15:0] a, input logic [15:0] dat,
                      input logic [3:0] b, input logic [1:0] s);
    exp_t e;
    int d;
    bit on;
    logic [15:0] dbg;
    logic [3:0] rise;
    @(negedge clk);
    writeM = we; addressM = a; outM = dat; btn_in = b; dbg_sel = s;
    e.chk_in = 1; e.inm = 0;
    if (a < 3840) begin
      if (ram_m.exists(int'(a))) e.inm = ram_m[int'(a)];
      else e.chk_in = 0;
    end else if (a < 3856) e.inm = (a == 3841) ? {8'h00, edge_m, s2} : io_m[a - 3840];
    on = n_edges >= 4;
    d = (n_edges / 4) % 4;
    dbg = io_m[12 + s];
    e.seg = on ? SEG[(dbg >> (4 * d)) & 16'hF] : 7'h7F;
    e.an = on ? ~(4'b0001 << d) : 4'hF;
    rise = s1 & ~s2;
    edge_m = (a == 3841) ? rise : (edge_m | rise);
    s2 = s1; s1 = b;
    if (we) begin
      if (a < 3840) ram_m[int'(a)] = dat;
      else if (a < 3856 && a != 3841) io_m[a - 3840] = dat;
    end
    e.led = io_m[0];
    n_edges++;
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    writeM = 0;
    rst = 1;
    #1;
    chk("rst_led", led_out, 0);
    chk("rst_inM", inM, 0);
    chk("rst_an", seg_an, 4'hF);
    chk("rst_seg", seg_out, 7'h7F);
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
    model_reset();
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk_in) chk("inM", inM, e.inm);
        chk("led_out", led_out, e.led);
        chk("seg_out", seg_out, e.seg);
        chk("seg_an", seg_an, e.an);
      end
    end
  end

  initial begin
    logic [15:0] a;
    model_reset();
    do_reset();
    // RAM write/read and unmapped read
    step(1, 16'h0005, 16'h1234, 0, 0);
    step(0, 16'h0005, 16'h0000, 0, 0);
    step(0, 16'h0F20, 16'h0000, 0, 0);
    // LED write, read-before-write, readback
    step(1, 16'd3840, 16'hA5A5, 0, 0);
    step(1, 16'd3840, 16'h5A5A, 0, 0);
    step(0, 16'd3840, 16'h0000, 0, 0);
    // button pulse, sticky capture, clear on read, read-only
    repeat (5) step(0, 16'h0F20, 0, 4'b0100, 0);
    repeat (3) step(0, 16'h0F20, 0, 4'b0000, 0);
    step(0, 16'd3841, 0, 0, 0);
    step(0, 16'd3841, 0, 0, 0);
    step(1, 16'd3841, 16'hFFFF, 0, 0);
    step(0, 16'd3841, 0, 0, 0);
    // new edge lands on the clearing read
    repeat (3) step(0, 16'h0F20, 0, 4'b0000, 0);
    step(0, 16'h0F20, 0, 4'b0001, 0);
    step(0, 16'd3841, 0, 4'b0001, 0);
    step(0, 16'd3841, 0, 4'b0001, 0);
    // display scan of the first debug register
    step(1, 16'd3852, 16'h3C7F, 4'b0001, 0);
    repeat (24) step(0, 16'h0F20, 0, 4'b0001, 0);
    do_reset();
    step(0, 16'h0005, 0, 0, 0);
    step(0, 16'd3840, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 3))
        0: a = 16'($urandom_range(0, 15));
        1: a = 16'(3840 + $urandom_range(0, 15));
        2: a = 16'($urandom_range(3856, 65535));
        default: a = 16'($urandom_range(16, 3839));
      endcase
      if ($urandom_range(0, 5) == 0) btn_cur = btn_cur ^ (4'b0001 << $urandom_range(0, 3));
      step($urandom_range(0, 9) < 4, a, 16'($urandom), btn_cur, 2'($urandom_range(0, 3)));
      if (i == 400) do_reset();
    end
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) chk("drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
